// File: rtl/hole_hit_checker.sv
// Position table filled by the random-position generator; each ball query scans
// the stored entries one per cycle and reports the first entry whose box holds the ball.
module hole_hit_checker #(
    parameter int MAX_NUM = 7,
    parameter int COORD_W = 10,
    parameter int RADIUS  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_wr_en,
    input  logic [COORD_W-1:0] i_wr_x,
    input  logic [COORD_W-1:0] i_wr_y,
    output logic               o_wr_ready,
    output logic [3:0]         o_count,
    output logic               o_full,
    input  logic               i_query_valid,
    input  logic [COORD_W-1:0] i_ball_x,
    input  logic [COORD_W-1:0] i_ball_y,
    output logic               o_query_ready,
    output logic               o_result_valid,
    output logic               o_hit,
    output logic [3:0]         o_hit_idx
);

    localparam logic [1:0]         ST_IDLE = 2'd0;
    localparam logic [1:0]         ST_SCAN = 2'd1;
    localparam logic [1:0]         ST_DONE = 2'd2;
    localparam logic [3:0]         MAX_CNT = 4'(MAX_NUM);
    localparam logic [COORD_W:0]   RAD     = (COORD_W+1)'(RADIUS);

    // One extra bit keeps the difference signed so 0 vs max-coordinate never wraps.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic [COORD_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[COORD_W]) begin
            abs_diff = -d;
        end else begin
            abs_diff = d;
        end
    endfunction

    logic [1:0]         state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic [3:0]         n_q, n_d;
    logic [3:0]         idx_q, idx_d;
    logic [COORD_W-1:0] ball_x_q, ball_x_d;
    logic [COORD_W-1:0] ball_y_q, ball_y_d;
    logic               hit_q, hit_d;
    logic [3:0]         hit_idx_q, hit_idx_d;
    logic [COORD_W-1:0] tab_x_q [16];
    logic [COORD_W-1:0] tab_y_q [16];

    logic full_s, wr_accept_s, q_accept_s, entry_hit_s;

    // Handshake decode and box test of the entry under the scan pointer.
    always_comb begin
        full_s      = (count_q == MAX_CNT);
        wr_accept_s = (state_q == ST_IDLE) && !full_s && i_wr_en && !i_clr;
        q_accept_s  = (state_q == ST_IDLE) && i_query_valid && !i_clr;
        entry_hit_s = (abs_diff(ball_x_q, tab_x_q[idx_q]) <= RAD) &&
                      (abs_diff(ball_y_q, tab_y_q[idx_q]) <= RAD);
    end

    // Next-state logic for the scan FSM, entry counter and result registers.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        n_d       = n_q;
        idx_d     = idx_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        if (i_clr) begin
            state_d   = ST_IDLE;
            count_d   = 4'd0;
            hit_d     = 1'b0;
            hit_idx_d = 4'd0;
        end else begin
            if (wr_accept_s) begin
                count_d = count_q + 4'd1;
            end else begin
                count_d = count_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (q_accept_s) begin
                        ball_x_d = i_ball_x;
                        ball_y_d = i_ball_y;
                        n_d      = count_q;
                        idx_d    = 4'd0;
                        if (count_q != 4'd0) begin
                            state_d = ST_SCAN;
                        end else begin
                            state_d   = ST_DONE;
                            hit_d     = 1'b0;
                            hit_idx_d = 4'd0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (entry_hit_s) begin
                        hit_d     = 1'b1;
                        hit_idx_d = idx_q;
                        state_d   = ST_DONE;
                    end else if (idx_q == n_q - 4'd1) begin
                        hit_d     = 1'b0;
                        hit_idx_d = 4'd0;
                        state_d   = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            count_q   <= 4'd0;
            n_q       <= 4'd0;
            idx_q     <= 4'd0;
            ball_x_q  <= '0;
            ball_y_q  <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    // Table storage; contents are meaningless past count, so no reset.
    always_ff @(posedge i_clk) begin
        if (wr_accept_s) begin
            tab_x_q[count_q] <= i_wr_x;
            tab_y_q[count_q] <= i_wr_y;
        end
    end

    assign o_wr_ready     = (state_q == ST_IDLE) && !full_s;
    assign o_query_ready  = (state_q == ST_IDLE);
    assign o_result_valid = (state_q == ST_DONE);
    assign o_count        = count_q;
    assign o_full         = full_s;
    assign o_hit          = hit_q;
    assign o_hit_idx      = hit_idx_q;

endmodule

// File: tb/tb_hole_hit_checker.sv
// Directed bench for hole_hit_checker: a vector table of queries against small
// tables plus hand sequences for fill, same-cycle write/query, clear and reset.
module tb_hole_hit_checker;

    logic       clk = 1'b0;
    logic       rst, clr, wr_en, q_valid;
    logic [9:0] wr_x, wr_y, ball_x, ball_y;
    logic       wr_ready, full, q_ready, res_valid, hit;
    logic [3:0] count, hit_idx;

    int total = 0;
    int bad   = 0;

    hole_hit_checker dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr),
        .i_wr_en(wr_en), .i_wr_x(wr_x), .i_wr_y(wr_y),
        .o_wr_ready(wr_ready), .o_count(count), .o_full(full),
        .i_query_valid(q_valid), .i_ball_x(ball_x), .i_ball_y(ball_y),
        .o_query_ready(q_ready), .o_result_valid(res_valid),
        .o_hit(hit), .o_hit_idx(hit_idx)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        wr_en = 1'b1; wr_x = x; wr_y = y;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Presents a query for one cycle; returns at the negedge of cycle 1.
    task automatic start_query(input logic [9:0] bx, input logic [9:0] by);
        @(negedge clk);
        q_valid = 1'b1; ball_x = bx; ball_y = by;
        @(negedge clk);
        q_valid = 1'b0;
    endtask

    task automatic do_query(input logic [9:0] bx, input logic [9:0] by,
                            output int lat, output logic h, output logic [3:0] idx);
        start_query(bx, by);
        lat = -1; h = 1'b0; idx = 4'd0;
        for (int c = 1; c <= 40; c++) begin
            if (res_valid) begin
                lat = c; h = hit; idx = hit_idx;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_table(input int t);
        do_clear();
        case (t)
            1: begin do_write(10'd10, 10'd10); do_write(10'd200, 10'd50); do_write(10'd300, 10'd300); end
            2: do_write(10'd50, 10'd50);
            3: do_write(10'd1023, 10'd1023);
            default: ;
        endcase
    endtask

    typedef struct {
        int         tbl;
        logic [9:0] bx;
        logic [9:0] by;
        logic       hit;
        logic [3:0] idx;
        int         lat;
    } vec_t;

    vec_t vecs[11];
    int   lat;
    logic h;
    logic [3:0] idx;
    int   cur_tbl;
    int   seen;

    initial begin
        vecs[0]  = '{0, 10'd100,  10'd100,  1'b0, 4'd0, 1};
        vecs[1]  = '{1, 10'd205,  10'd45,   1'b1, 4'd1, 3};
        vecs[2]  = '{1, 10'd500,  10'd500,  1'b0, 4'd0, 4};
        vecs[3]  = '{1, 10'd10,   10'd18,   1'b1, 4'd0, 2};
        vecs[4]  = '{1, 10'd308,  10'd292,  1'b1, 4'd2, 4};
        vecs[5]  = '{1, 10'd309,  10'd300,  1'b0, 4'd0, 4};
        vecs[6]  = '{2, 10'd58,   10'd42,   1'b1, 4'd0, 2};
        vecs[7]  = '{2, 10'd59,   10'd50,   1'b0, 4'd0, 2};
        vecs[8]  = '{2, 10'd42,   10'd58,   1'b1, 4'd0, 2};
        vecs[9]  = '{3, 10'd0,    10'd0,    1'b0, 4'd0, 2};
        vecs[10] = '{3, 10'd1015, 10'd1023, 1'b1, 4'd0, 2};

        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; q_valid = 1'b0;
        wr_x = 10'd0; wr_y = 10'd0; ball_x = 10'd0; ball_y = 10'd0;
        repeat (2) @(negedge clk);
        chk("rst_q_ready", int'(q_ready), 1);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_idx", int'(hit_idx), 0);
        rst = 1'b0;

        cur_tbl = 0;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].tbl != cur_tbl) begin
                load_table(vecs[i].tbl);
                cur_tbl = vecs[i].tbl;
            end
            do_query(vecs[i].bx, vecs[i].by, lat, h, idx);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_hit", i), int'(h), int'(vecs[i].hit));
            chk($sformatf("vec%0d_idx", i), int'(idx), int'(vecs[i].idx));
        end
        @(negedge clk);
        chk("pulse_one_cycle", int'(res_valid), 0);
        chk("hit_held", int'(hit), 1);

        // Fill to capacity; extra write is dropped.
        do_clear();
        for (int i = 0; i < 7; i++) do_write(10'(i * 100), 10'(i * 100));
        chk("fill_count", int'(count), 7);
        chk("fill_full", int'(full), 1);
        chk("fill_wr_ready", int'(wr_ready), 0);
        do_write(10'd900, 10'd900);
        chk("fill_8th_count", int'(count), 7);

        // Write presented during a scan is ignored.
        load_table(1);
        start_query(10'd500, 10'd500);
        chk("scan_wr_ready", int'(wr_ready), 0);
        chk("scan_q_ready", int'(q_ready), 0);
        wr_en = 1'b1; wr_x = 10'd1; wr_y = 10'd1;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("scan_wr_count", int'(count), 3);

        // Same-cycle write and query: snapshot excludes the new entry.
        @(negedge clk);
        q_valid = 1'b1; ball_x = 10'd400; ball_y = 10'd400;
        wr_en = 1'b1; wr_x = 10'd400; wr_y = 10'd400;
        @(negedge clk);
        q_valid = 1'b0; wr_en = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (res_valid) begin lat = c; h = hit; break; end
            @(negedge clk);
        end
        chk("same_cyc_lat", lat, 4);
        chk("same_cyc_hit", int'(h), 0);
        chk("same_cyc_count", int'(count), 4);
        do_query(10'd400, 10'd400, lat, h, idx);
        chk("new_entry_lat", lat, 5);
        chk("new_entry_hit", int'(h), 1);
        chk("new_entry_idx", int'(idx), 3);

        // Clear during cycle 2 of a 5-entry scan.
        do_clear();
        for (int i = 0; i < 5; i++) do_write(10'(i * 10), 10'd0);
        do_query(10'd0, 10'd0, lat, h, idx);
        chk("pre_clr_hit", int'(h), 1);
        start_query(10'd900, 10'd900);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_q_ready", int'(q_ready), 1);
        chk("clr_count", int'(count), 0);
        chk("clr_hit", int'(hit), 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        chk("clr_no_pulse", seen, 0);

        // Async reset mid-scan.
        for (int i = 0; i < 5; i++) do_write(10'(i * 10), 10'd0);
        do_query(10'd40, 10'd0, lat, h, idx);
        chk("pre_rst_idx", int'(idx), 4);
        start_query(10'd900, 10'd900);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_q_ready", int'(q_ready), 1);
        chk("arst_wr_ready", int'(wr_ready), 1);
        chk("arst_count", int'(count), 0);
        chk("arst_hit", int'(hit), 0);
        chk("arst_idx", int'(hit_idx), 0);
        chk("arst_valid", int'(res_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        chk("arst_no_pulse", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
